// File: rtl/spi_peripheral.sv
// -----------------------------------------------------------------------------
// spi_peripheral
//   SPI peripheral (target) with a one-byte TX holding register and a one-byte
//   RX output register. All SPI pins are asynchronous to clk and pass through
//   2-flop synchronizers; SCLK edges are detected in the clk domain, so clk
//   must run at least 8x the SCLK frequency.
//
// Parameters
//   CPOL  : SCLK idle level.
//   CPHA  : 0 = sample on leading edge, 1 = sample on trailing edge.
//
// Ports
//   clk, rst            : system clock, asynchronous active-high reset
//   spi_sclk/cs_n/mosi  : SPI inputs from the controller (asynchronous)
//   spi_miso, spi_miso_oe : MISO data and its drive enable
//   tx_data/tx_valid/tx_ready : write port of the TX holding register
//                          (valid/ready: a byte is taken on any cycle where
//                          tx_valid && tx_ready; tx_valid with tx_ready=0 is
//                          ignored, there is no queueing)
//   rx_data, rx_valid   : last complete byte, one-cycle pulse after update
//   busy                : synchronized chip select is low
//   tx_underrun         : pulse when a byte load finds the holding reg empty
//   frame_abort         : pulse when CS rises in the middle of a byte
// -----------------------------------------------------------------------------
module spi_peripheral #(
    parameter bit CPOL = 1'b1,
    parameter bit CPHA = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       tx_underrun,
    output logic       frame_abort
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t     state;
    logic       sclk_s1, sclk_s2, sclk_d;
    logic       cs_s1, cs_s2;
    logic       mosi_s1, mosi_s2;
    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic [7:0] tx_shift;
    logic [7:0] hold;
    logic       hold_full;
    logic       rx_done;

    logic in_frame, lead_edge, trail_edge, sample_edge, shift_edge, load_point;

    // Synchronizers. Reset values match the bus idle state so that releasing
    // reset never looks like an SCLK edge or a CS fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_s1 <= CPOL;
            sclk_s2 <= CPOL;
            sclk_d  <= CPOL;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sclk_s1 <= spi_sclk;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            cs_s1   <= spi_cs_n;
            cs_s2   <= cs_s1;
            mosi_s1 <= spi_mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    always_comb begin
        in_frame    = (state == ACTIVE) && !cs_s2;
        lead_edge   = in_frame && (sclk_d == CPOL) && (sclk_s2 != CPOL);
        trail_edge  = in_frame && (sclk_d != CPOL) && (sclk_s2 == CPOL);
        sample_edge = CPHA ? trail_edge : lead_edge;
        shift_edge  = CPHA ? lead_edge : trail_edge;
        // A shift edge with the counter at 0 is always a byte boundary: for
        // CPHA=1 it is the first edge of a byte, for CPHA=0 it follows the
        // 8th sample. CPHA=0 additionally needs the first bit on CS fall.
        load_point  = (shift_edge && (bit_cnt == 3'd0)) ||
                      (!CPHA && (state == IDLE) && !cs_s2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= 3'd0;
            rx_shift    <= 8'h00;
            tx_shift    <= 8'h00;
            hold        <= 8'h00;
            hold_full   <= 1'b0;
            rx_data     <= 8'h00;
            rx_done     <= 1'b0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            rx_valid    <= rx_done;
            rx_done     <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;

            case (state)
                IDLE: begin
                    if (!cs_s2) state <= ACTIVE;
                end
                ACTIVE: begin
                    if (cs_s2) begin
                        state    <= IDLE;
                        bit_cnt  <= 3'd0;
                        rx_shift <= 8'h00;
                        if (bit_cnt != 3'd0) frame_abort <= 1'b1;
                    end else begin
                        if (sample_edge) begin
                            rx_shift <= {rx_shift[6:0], mosi_s2};
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_data <= {rx_shift[6:0], mosi_s2};
                                rx_done <= 1'b1;
                            end
                        end
                        if (shift_edge && !load_point) begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (load_point) begin
                if (hold_full) begin
                    tx_shift  <= hold;
                    hold_full <= 1'b0;
                end else begin
                    tx_shift    <= 8'h00;
                    tx_underrun <= 1'b1;
                end
            end

            // Placed after the load so a write landing on an underrunning
            // load point still fills the holding register for the next byte.
            if (tx_valid && !hold_full) begin
                hold      <= tx_data;
                hold_full <= 1'b1;
            end
        end
    end

    assign busy        = (state == ACTIVE);
    assign spi_miso_oe = busy;
    assign spi_miso    = busy & tx_shift[7];
    assign tx_ready    = ~hold_full;

endmodule

// File: tb/tb_spi_peripheral.sv
// -----------------------------------------------------------------------------
// tb_spi_peripheral
//   Two instances: "a" in mode CPOL=1/CPHA=1 and "b" in mode CPOL=0/CPHA=0.
//   Expected RX bytes go into per-instance queues when a frame is issued; a
//   monitor pops them whenever rx_valid pulses. MISO bytes, pulse counts and
//   reset values are compared directly against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_spi_peripheral;

  localparam time HALF = 80ns;

  logic       clk;
  logic       rst;

  logic       a_sclk, a_cs_n, a_mosi, a_miso, a_miso_oe;
  logic [7:0] a_tx_data, a_rx_data;
  logic       a_tx_valid, a_tx_ready, a_rx_valid, a_busy, a_tx_underrun, a_frame_abort;

  logic       b_sclk, b_cs_n, b_mosi, b_miso, b_miso_oe;
  logic [7:0] b_tx_data, b_rx_data;
  logic       b_tx_valid, b_tx_ready, b_rx_valid, b_busy, b_tx_underrun, b_frame_abort;

  int n_checks = 0;
  int n_fail   = 0;
  int a_und_cnt = 0, a_abort_cnt = 0, b_und_cnt = 0;

  logic [7:0] a_exp_q[$];
  logic [7:0] b_exp_q[$];

  spi_peripheral #(.CPOL(1'b1), .CPHA(1'b1)) dut_a (
    .clk(clk), .rst(rst),
    .spi_sclk(a_sclk), .spi_cs_n(a_cs_n), .spi_mosi(a_mosi),
    .spi_miso(a_miso), .spi_miso_oe(a_miso_oe),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .rx_data(a_rx_data), .rx_valid(a_rx_valid), .busy(a_busy),
    .tx_underrun(a_tx_underrun), .frame_abort(a_frame_abort)
  );

  spi_peripheral #(.CPOL(1'b0), .CPHA(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .spi_sclk(b_sclk), .spi_cs_n(b_cs_n), .spi_mosi(b_mosi),
    .spi_miso(b_miso), .spi_miso_oe(b_miso_oe),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .rx_data(b_rx_data), .rx_valid(b_rx_valid), .busy(b_busy),
    .tx_underrun(b_tx_underrun), .frame_abort(b_frame_abort)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5ns clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitors and pulse counters
  always @(negedge clk) begin
    if (a_rx_valid) begin
      n_checks++;
      if (a_exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL a_rx_unexpected: got rx_data 0x%0h, expected no rx_valid", a_rx_data);
      end else begin
        logic [7:0] e;
        e = a_exp_q.pop_front();
        if (a_rx_data !== e) begin
          n_fail++;
          $display("FAIL a_rx_data: got 0x%0h, expected 0x%0h", a_rx_data, e);
        end
      end
    end
    if (b_rx_valid) begin
      n_checks++;
      if (b_exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL b_rx_unexpected: got rx_data 0x%0h, expected no rx_valid", b_rx_data);
      end else begin
        logic [7:0] e;
        e = b_exp_q.pop_front();
        if (b_rx_data !== e) begin
          n_fail++;
          $display("FAIL b_rx_data: got 0x%0h, expected 0x%0h", b_rx_data, e);
        end
      end
    end
    if (a_tx_underrun) a_und_cnt++;
    if (a_frame_abort) a_abort_cnt++;
    if (b_tx_underrun) b_und_cnt++;
  end

  // driver tasks
  task automatic a_write(input logic [7:0] d);
    int t = 0;
    while (!a_tx_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("a_tx_ready_wait", a_tx_ready, 1);
    @(negedge clk);
    a_tx_data  = d;
    a_tx_valid = 1'b1;
    @(negedge clk);
    a_tx_valid = 1'b0;
  endtask

  task automatic b_write(input logic [7:0] d);
    int t = 0;
    while (!b_tx_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("b_tx_ready_wait", b_tx_ready, 1);
    @(negedge clk);
    b_tx_data  = d;
    b_tx_valid = 1'b1;
    @(negedge clk);
    b_tx_valid = 1'b0;
  endtask

  // Mode 3 controller: change MOSI on the falling (leading) edge, sample MISO
  // just before the rising (trailing) edge.
  task automatic a_bit(input logic b, output logic o);
    a_sclk = 1'b0;
    a_mosi = b;
    #HALF;
    o = a_miso;
    a_sclk = 1'b1;
    #HALF;
  endtask

  task automatic a_frame(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    logic bo;
    mi = 8'h00;
    a_cs_n = 1'b0;
    #HALF;
    check("a_busy_in_frame", a_busy, 1);
    check("a_miso_oe_in_frame", a_miso_oe, 1);
    for (int i = 7; i > 7 - nbits; i--) begin
      a_bit(mo[i], bo);
      mi[i] = bo;
    end
    #HALF;
    a_cs_n = 1'b1;
    #(3 * HALF);
  endtask

  // Mode 0 controller: MOSI set half a period before the rising (leading)
  // edge, MISO sampled just before it; SCLK falls at the end of each bit.
  task automatic b_byte(input logic [7:0] mo, output logic [7:0] mi);
    for (int i = 7; i >= 0; i--) begin
      b_mosi = mo[i];
      #HALF;
      mi[i] = b_miso;
      b_sclk = 1'b1;
      #HALF;
      b_sclk = 1'b0;
    end
  endtask

  task automatic check_a_reset_values(input string tag);
    check({tag, "_tx_ready"}, a_tx_ready, 1);
    check({tag, "_rx_data"}, a_rx_data, 8'h00);
    check({tag, "_rx_valid"}, a_rx_valid, 0);
    check({tag, "_miso"}, a_miso, 0);
    check({tag, "_miso_oe"}, a_miso_oe, 0);
    check({tag, "_busy"}, a_busy, 0);
    check({tag, "_tx_underrun"}, a_tx_underrun, 0);
    check({tag, "_frame_abort"}, a_frame_abort, 0);
  endtask

  initial begin
    logic [7:0] mi, m1, m2;
    int u0, ab0;

    rst = 1'b1;
    a_sclk = 1'b1; a_cs_n = 1'b1; a_mosi = 1'b0; a_tx_data = 8'h00; a_tx_valid = 1'b0;
    b_sclk = 1'b0; b_cs_n = 1'b1; b_mosi = 1'b0; b_tx_data = 8'h00; b_tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_a_reset_values("rst");
    check("rst_b_tx_ready", b_tx_ready, 1);
    check("rst_b_busy", b_busy, 0);
    check("rst_b_miso", b_miso, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_a_busy", a_busy, 0);

    // Mode 0, two back-to-back bytes under one CS; a third byte is preloaded
    // so the load after the final sample finds data.
    b_write(8'h81);
    u0 = b_und_cnt;
    b_exp_q.push_back(8'h55);
    b_exp_q.push_back(8'hAA);
    b_cs_n = 1'b0;
    fork
      begin
        b_byte(8'h55, m1);
        b_byte(8'hAA, m2);
      end
      begin
        b_write(8'h7E);
        b_write(8'hFF);
      end
    join
    #HALF;
    b_cs_n = 1'b1;
    #(3 * HALF);
    check("b_miso_byte1", m1, 8'h81);
    check("b_miso_byte2", m2, 8'h7E);
    check("b_underruns", b_und_cnt - u0, 0);

    // Mode 3, single byte.
    a_write(8'hA5);
    check("a_tx_ready_after_write", a_tx_ready, 0);
    u0 = a_und_cnt;
    a_exp_q.push_back(8'h3C);
    a_frame(8'h3C, 8, mi);
    check("a_miso_A5", mi, 8'hA5);
    check("a_tx_ready_after_frame", a_tx_ready, 1);
    check("a_underruns_A5", a_und_cnt - u0, 0);

    // No TX write: MISO all zeros, one underrun.
    u0 = a_und_cnt;
    a_exp_q.push_back(8'h96);
    a_frame(8'h96, 8, mi);
    check("a_miso_underrun", mi, 8'h00);
    check("a_underruns_empty", a_und_cnt - u0, 1);

    // Abort after 5 bits, then a full frame.
    u0 = a_und_cnt;
    ab0 = a_abort_cnt;
    a_frame(8'hFF, 5, mi);
    check("a_abort_pulse", a_abort_cnt - ab0, 1);
    check("a_abort_underrun", a_und_cnt - u0, 1);
    check("a_rx_data_held", a_rx_data, 8'h96);
    a_write(8'h5A);
    a_exp_q.push_back(8'hE7);
    a_frame(8'hE7, 8, mi);
    check("a_miso_after_abort", mi, 8'h5A);
    check("a_no_extra_abort", a_abort_cnt - ab0, 1);

    // Reset in the middle of a byte.
    ab0 = a_abort_cnt;
    a_cs_n = 1'b0;
    #HALF;
    for (int i = 0; i < 3; i++) begin
      logic bo;
      a_bit(1'b1, bo);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_a_reset_values("midrst");
    a_cs_n = 1'b1;
    a_sclk = 1'b1;
    a_mosi = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst_no_abort", a_abort_cnt - ab0, 0);
    a_write(8'h3C);
    a_exp_q.push_back(8'hC3);
    a_frame(8'hC3, 8, mi);
    check("a_miso_after_rst", mi, 8'h3C);

    // tx_valid held while tx_ready=0: second byte is ignored.
    @(negedge clk);
    a_tx_data  = 8'h11;
    a_tx_valid = 1'b1;
    @(negedge clk);
    a_tx_data  = 8'h22;
    @(negedge clk);
    check("a_tx_ready_held", a_tx_ready, 0);
    a_tx_valid = 1'b0;
    a_exp_q.push_back(8'h0F);
    a_frame(8'h0F, 8, mi);
    check("a_miso_first_kept", mi, 8'h11);

    repeat (10) @(negedge clk);
    check("a_queue_drained", a_exp_q.size(), 0);
    check("b_queue_drained", b_exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_peripheral.md
SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 SHALL have parameter CPOL, default 1, meaning SCLK idle level.
REQ-002 SHALL have parameter CPHA, default 1; 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-003 SHALL have port clk, input, 1, system clock; all logic on posedge clk.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port spi_sclk, input, 1, SPI clock from controller, asynchronous to clk.
REQ-006 SHALL have port spi_cs_n, input, 1, active-low chip select, asynchronous.
REQ-007 SHALL have port spi_mosi, input, 1, controller-to-peripheral data, asynchronous.
REQ-008 SHALL have port spi_miso, output, 1, peripheral-to-controller data.
REQ-009 SHALL have port spi_miso_oe, output, 1, MISO drive enable.
REQ-010 SHALL have port tx_data, input, 8, byte to transmit.
REQ-011 SHALL have port tx_valid, input, 1, tx_data write strobe.
REQ-012 SHALL have port tx_ready, output, 1, TX holding register empty.
REQ-013 SHALL have port rx_data, output, 8, last complete received byte.
REQ-014 SHALL have port rx_valid, output, 1, one-cycle pulse when rx_data updates.
REQ-015 SHALL have port busy, output, 1, chip select active (synchronized).
REQ-016 SHALL have port tx_underrun, output, 1, one-cycle pulse when a byte load finds the holding register empty.
REQ-017 SHALL have port frame_abort, output, 1, one-cycle pulse when CS deasserts mid-byte.

Function
REQ-018 SHALL pass spi_sclk, spi_cs_n and spi_mosi through 2-flop synchronizers; edge detection SHALL use synchronized values only.
REQ-019 SHALL operate correctly for clk frequency >= 8x SCLK frequency.
REQ-020 Leading edge = synchronized SCLK leaving CPOL; trailing edge = returning to CPOL; sample edge per CPHA; shift edge = the other edge.
REQ-021 Edges SHALL be ignored while synchronized CS is high; busy = synchronized CS low.
REQ-022 Transfers SHALL be MSB first, 8 bits per byte, back-to-back bytes allowed while CS stays low.
REQ-023 FSM states: IDLE (CS high), ACTIVE (CS low, shifting); IDLE->ACTIVE on CS fall, ACTIVE->IDLE on CS rise.
REQ-024 TX holding register: tx_valid && tx_ready SHALL capture tx_data; tx_ready SHALL drop the next cycle; tx_valid while tx_ready=0 SHALL be ignored.
REQ-025 Byte load point: CPHA=0, on CS fall and on the shift edge following each 8th sample; CPHA=1, on the first shift edge of each byte.
REQ-026 At a load point, the TX shift register SHALL take the holding register and set tx_ready=1; if the holding register is empty, it SHALL take 0x00 and pulse tx_underrun.
REQ-027 A tx_valid write in the same cycle as a load point with an empty holding register SHALL fill the holding register for the next byte, and the current byte SHALL still underrun.
REQ-028 On each sample edge, synchronized MOSI SHALL shift into the RX register LSB and the 3-bit bit counter SHALL increment, wrapping 7->0.
REQ-029 On the 8th sample edge, rx_data SHALL update and rx_valid SHALL pulse 1 cycle later; there is no backpressure, and rx_data SHALL hold until the next byte.
REQ-030 spi_miso SHALL present the TX shift register MSB; spi_miso_oe SHALL equal busy; spi_miso SHALL be 0 when not busy.
REQ-031 CS rise with bit counter != 0 SHALL pulse frame_abort, discard partial RX bits without an rx_valid pulse, and clear the bit counter; the holding register SHALL be preserved.
REQ-032 CS rise with bit counter == 0 SHALL end the frame silently.

Reset
REQ-033 While rst=1: state IDLE, counter 0, shift registers 0, holding register empty.
REQ-034 While rst=1: tx_ready=1, rx_data=0x00, rx_valid=0, spi_miso=0, spi_miso_oe=0, busy=0, tx_underrun=0, frame_abort=0.
REQ-035 Synchronizer flops SHALL reset to CS high, SCLK=CPOL, MOSI=0; no spurious edge SHALL be detected on reset release.
REQ-036 Reset mid-frame SHALL abort immediately without pulsing rx_valid or frame_abort.

Verification
REQ-037 CPOL=1/CPHA=1, write tx 0xA5, controller sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; rx_data=0x3C; one rx_valid; tx_ready back to 1.
REQ-038 CPOL=0/CPHA=0, two back-to-back bytes (tx 0x81, 0x7E; rx 0x55, 0xAA) with CS held low -> two rx_valid pulses, values matching, no underrun.
REQ-039 No tx write before CS fall -> MISO all 0s, one tx_underrun pulse, rx still correct.
REQ-040 CS rise after 5 SCLK cycles -> frame_abort pulse, no rx_valid; next full frame received correctly.
REQ-041 Assert rst mid-byte -> all outputs at reset values; after release, a 0xC3 frame is received correctly.
REQ-042 tx_valid held with tx_ready=0 -> second byte ignored, holding register keeps the first value.
